// File: rtl/alu_div_pkg.sv
// alu_div_pkg -- shared state encoding and width constants for the DIV/IDIV engine.
// Rev 1.0
`default_nettype none

package alu_div_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    ITER  = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int N_BYTE = 8;
  localparam int N_WORD = 16;

  localparam logic [15:0] MIN_NEG_BYTE = 16'h0080;
  localparam logic [15:0] MIN_NEG_WORD = 16'h8000;

endpackage

`default_nettype wire

// File: rtl/alu_div_step.sv
// alu_div_step -- one combinational non-restoring division step.
// Rev 1.0
`default_nettype none

module alu_div_step
  import alu_div_pkg::*;
(
  input  logic [N_WORD:0]   pr,
  input  logic              shift_in,
  input  logic [N_WORD-1:0] dvs,
  input  logic              byte_word,
  output logic [N_WORD:0]   pr_next,
  output logic              q_bit
);

  logic [N_WORD+1:0] shifted;
  logic [N_WORD+1:0] res;

  // 2*pr+bit needs one guard bit above the stored partial remainder before the add/subtract.
  always_comb begin
    shifted = {pr, shift_in};
    res     = pr[N_WORD] ? (shifted + {2'b00, dvs}) : (shifted - {2'b00, dvs});
    pr_next = byte_word ? res[N_WORD:0]
                        : {{(N_WORD - N_BYTE){res[N_BYTE]}}, res[N_BYTE:0]};
    q_bit   = ~res[N_WORD+1];
  end

endmodule

`default_nettype wire

// File: rtl/alu_div.sv
// alu_div -- sequential non-restoring DIV/IDIV engine for the 8088 execution unit.
// Rev 1.0
`default_nettype none

module alu_div
  import alu_div_pkg::*;
#(
  parameter int SIGNED_MIN_ERR = 1
) (
  input  logic        CLKx4,
  input  logic        RESETn,
  input  logic        start,
  input  logic        byteWord,
  input  logic        signedOp,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic        divideError,
  output logic [15:0] quotient,
  output logic [15:0] remainder
);

  state_t      state, state_next;
  logic        bw, sg, dvd_neg_flag, quo_neg_flag;
  logic [31:0] dvd;
  logic [15:0] dvs;
  logic [16:0] pr;
  logic [15:0] quo_acc;
  logic [4:0]  cnt;

  logic        dvd_sign, dvs_sign, prep_err;
  logic [31:0] dvd_mag;
  logic [15:0] dvs_abs, dvs_mag, hi_mag, lo_mag;
  logic [15:0] rem_mag, quo_mag, quo_neg, rem_neg, quo_out, rem_out, min_neg;
  logic        range_err;
  logic [16:0] pr_next;
  logic        q_bit;

  alu_div_step u_step (
    .pr        (pr),
    .shift_in  (bw ? quo_acc[15] : quo_acc[7]),
    .dvs       (dvs),
    .byte_word (bw),
    .pr_next   (pr_next),
    .q_bit     (q_bit)
  );

  // Magnitudes and overflow precheck, meaningful while in PREP on the raw captured operands.
  always_comb begin
    dvd_sign = sg & (bw ? dvd[31] : dvd[15]);
    dvs_sign = sg & (bw ? dvs[15] : dvs[7]);
    dvd_mag  = dvd_sign ? -dvd : dvd;
    dvs_abs  = dvs_sign ? -dvs : dvs;
    dvs_mag  = bw ? dvs_abs : {8'h00, dvs_abs[7:0]};
    hi_mag   = bw ? dvd_mag[31:16] : {8'h00, dvd_mag[15:8]};
    lo_mag   = bw ? dvd_mag[15:0]  : {8'h00, dvd_mag[7:0]};
    prep_err = (dvs_mag == 16'h0000) || (hi_mag >= dvs_mag);
  end

  always_comb begin
    rem_mag = pr[16] ? (pr[15:0] + dvs) : pr[15:0];
    quo_mag = bw ? quo_acc : {8'h00, quo_acc[7:0]};
    quo_neg = -quo_mag;
    rem_neg = -rem_mag;
    quo_out = quo_neg_flag ? quo_neg : quo_mag;
    rem_out = dvd_neg_flag ? rem_neg : rem_mag;
    if (!bw) begin
      quo_out[15:8] = 8'h00;
      rem_out[15:8] = 8'h00;
    end
    min_neg   = bw ? MIN_NEG_WORD : MIN_NEG_BYTE;
    range_err = sg && ((quo_mag > min_neg) ||
                       ((quo_mag == min_neg) && ((SIGNED_MIN_ERR != 0) || !quo_neg_flag)));
  end

  always_ff @(posedge CLKx4 or negedge RESETn) begin
    if (!RESETn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  if (start) state_next = PREP;
      PREP:  begin
        busy       = 1'b1;
        state_next = prep_err ? DONE : ITER;
      end
      ITER:  begin
        busy = 1'b1;
        if (cnt == 5'd1) state_next = FIXUP;
      end
      FIXUP: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE:  begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLKx4 or negedge RESETn) begin
    if (!RESETn) begin
      bw           <= 1'b0;
      sg           <= 1'b0;
      dvd          <= '0;
      dvs          <= '0;
      pr           <= '0;
      quo_acc      <= '0;
      cnt          <= '0;
      dvd_neg_flag <= 1'b0;
      quo_neg_flag <= 1'b0;
      divideError  <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          bw          <= byteWord;
          sg          <= signedOp;
          dvd         <= byteWord ? dividend : {16'h0000, dividend[15:0]};
          dvs         <= byteWord ? divisor  : {8'h00, divisor[7:0]};
          divideError <= 1'b0;
        end
        PREP: begin
          dvd_neg_flag <= dvd_sign;
          quo_neg_flag <= dvd_sign ^ dvs_sign;
          if (prep_err) begin
            divideError <= 1'b1;
          end else begin
            pr      <= {1'b0, hi_mag};
            quo_acc <= lo_mag;
            dvs     <= dvs_mag;
            cnt     <= bw ? 5'(N_WORD) : 5'(N_BYTE);
          end
        end
        ITER: begin
          pr      <= pr_next;
          quo_acc <= {quo_acc[14:0], q_bit};
          cnt     <= cnt - 5'd1;
        end
        FIXUP: begin
          if (range_err) begin
            divideError <= 1'b1;
          end else begin
            quotient  <= quo_out;
            remainder <= rem_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/alu_div.md
Name: alu_div

Overview:
- Sequential DIV/IDIV engine for the 8088 core. It performs the inverse of the multiply path that feeds the combinational ALU.
- Accepts a 16/32-bit dividend and an 8/16-bit divisor and returns quotient, remainder and a divide-error indication.
- Uses non-restoring division, one quotient bit per clock.
- Sits beside the ALU in the execution unit. The sequencer starts it and waits on done.

Parameters:
SIGNED_MIN_ERR, 1, when 1 a signed quotient equal to the most negative value (-128 / -32768) raises divideError, matching 8088 IDIV behaviour.

Ports:
CLKx4  input  1  core clock, all state on rising edge
RESETn  input  1  asynchronous active-low reset
start  input  1  request, sampled only in IDLE
byteWord  input  1  0 = byte (AX / r8), 1 = word (DX:AX / r16)
signedOp  input  1  0 = DIV, 1 = IDIV
dividend  input  32  byte mode uses [15:0], word mode uses [31:0]; captured when start is accepted
divisor  input  16  byte mode uses [7:0]; captured when start is accepted
busy  output  1  high from the accept edge until done
done  output  1  one-cycle pulse when results are valid
divideError  output  1  valid with done, held until next accept
quotient  output  16  byte mode in [7:0], [15:8]=0
remainder  output  16  byte mode in [7:0], [15:8]=0

Behaviour:
- Reset (async, RESETn=0): state IDLE; busy=0, done=0, divideError=0, quotient=0, remainder=0.
- Parameters by mode: N=8 (byte) or 16 (word); high half = dividend bits [2N-1:N].
- States: IDLE, PREP, ITER, FIXUP, DONE.
- IDLE:
  - start=1 captures the operands, sets busy, goes to PREP (edge 1).
  - start is ignored in every other state.
- PREP:
  - Takes magnitudes when signedOp=1 and records sign(dividend) and sign(dividend)^sign(divisor).
  - Error precheck, evaluated in order:
    - divisor==0, then
    - |high half| >= |divisor|.
  - Either check true → DONE with error.
  - Otherwise load the partial remainder and count=N, then go to ITER.
- ITER:
  - One non-restoring step per cycle: shift, add or subtract the divisor magnitude by partial-remainder sign, shift in the quotient bit.
  - Runs exactly N cycles, then goes to FIXUP.
- FIXUP:
  - Final remainder correction (add the divisor if negative).
  - Negate the quotient if the sign flag is set; the remainder takes the dividend's sign.
  - Signed range check: quotient magnitude > 2^(N-1)-1 (or == 2^(N-1) with SIGNED_MIN_ERR=1) → error.
  - Then go to DONE.
- DONE:
  - done=1 for exactly one cycle; busy=0 in the same cycle; return to IDLE.
  - No error: quotient and remainder update in this cycle.
  - Error: quotient and remainder keep their previous values; divideError=1.
- Latency from the start-sampling edge:
  - done is high after edge N+3 (byte 11, word 19).
  - On a PREP error, done is high after edge 2.
- start held high continuously → a new operation is accepted on the first IDLE cycle after DONE. There is no back-to-back overlap.
- RESETn asserted mid-operation: immediate abort to reset values; no done pulse.
- Width rules: internal partial remainder is N+1 bits. Zero-extend all unused upper bits of the outputs.

Decomposition:
- Shared package alu_div_pkg holds:
  - state enum (IDLE, PREP, ITER, FIXUP, DONE)
  - N_BYTE=8, N_WORD=16
  - MIN_NEG_BYTE=16'h0080, MIN_NEG_WORD=16'h8000
- One sub-module, alu_div_step: combinational single non-restoring iteration (partial remainder, divisor, byteWord → next partial remainder, quotient bit).
- The FSM, counter and sign/fixup logic stay in alu_div.

Test Plan:
- Word DIV, dividend=32'h0001_0000, divisor=16'h0003 → quotient=16'h5555, remainder=16'h0001, divideError=0, done after edge 19, busy low same cycle.
- Byte IDIV, dividend=16'hFF9C (-100), divisor=16'h0007 → quotient=16'h00F2 (-14), remainder=16'h00FE (-2), done after edge 11.
- Byte DIV by zero, dividend=16'h1234, divisor=0 → divideError=1 and done after edge 2; quotient and remainder keep the prior results.
- Word DIV overflow, dividend=32'h0003_0000, divisor=16'h0002 → precheck error, done after edge 2.
- Byte IDIV, dividend=16'h4000, divisor=16'h0080 (-128) → quotient magnitude 0x80, FIXUP error with SIGNED_MIN_ERR=1, done after edge 11.
- Start pulse while busy is ignored (single done). RESETn low at edge 5 of a word op → outputs zero, no done; a new start afterwards completes normally.
